// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin two-master data-bus arbiter with address decode,
// multi-cycle DM sequencing and illegal-access flagging.
module mem_bus_arbiter #(
  parameter int          DM_LATENCY = 2,
  parameter logic [31:0] DM_TOP     = 32'h0000_2FFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [3:0]  m0_byteen,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [3:0]  m1_byteen,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byteen,
  output logic [31:0] bus_wdata,
  output logic        dm_we,
  output logic        tc1_we,
  output logic        tc2_we,
  output logic        int_we,
  input  logic [31:0] dm_rdata,
  input  logic [31:0] tc1_rdata,
  input  logic [31:0] tc2_rdata,
  input  logic [31:0] int_rdata,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;
  typedef enum logic [2:0] {R_DM, R_TC1, R_TC2, R_INT, R_ERR} region_t;

  state_t      r_state, w_next;
  region_t     r_region, w_region;
  logic        r_last, r_owner, r_first, r_we;
  logic [3:0]  r_cnt, r_be;
  logic [31:0] r_addr, r_wdata;

  logic        w_any, w_gnt1, w_we, w_dm, w_t1, w_t2, w_int, w_bad, w_ack, w_stb;
  logic [31:0] w_addr, w_wdata, w_rd;
  logic [3:0]  w_be;

  // last grant resets to M1 so M0 wins the first tie
  assign w_any   = m0_req | m1_req;
  assign w_gnt1  = m1_req & (~m0_req | ~r_last);
  assign w_addr  = w_gnt1 ? m1_addr   : m0_addr;
  assign w_we    = w_gnt1 ? m1_we     : m0_we;
  assign w_be    = w_gnt1 ? m1_byteen : m0_byteen;
  assign w_wdata = w_gnt1 ? m1_wdata  : m0_wdata;

  assign w_dm  = w_addr <= DM_TOP;
  assign w_t1  = w_addr >= 32'h7F00 && w_addr <= 32'h7F0B;
  assign w_t2  = w_addr >= 32'h7F10 && w_addr <= 32'h7F1B;
  assign w_int = w_addr >= 32'h7F20 && w_addr <= 32'h7F23;
  // peripherals are word-only and the timer count register is read-only
  assign w_bad = (w_be == 4'h0) | ~(w_dm | w_t1 | w_t2 | w_int)
               | ((w_t1 | w_t2 | w_int) & (w_be != 4'hF))
               | (w_we & (w_t1 | w_t2) & (w_addr[3:2] == 2'b10));

  always_comb begin
    w_region = w_bad ? R_ERR : w_dm ? R_DM : w_t1 ? R_TC1 : w_t2 ? R_TC2 : R_INT;
    w_next   = (r_state == IDLE)   ? (w_any ? ACCESS : IDLE) :
               (r_state == ACCESS) ? (r_cnt == 4'd0 ? RECOVER : ACCESS) : IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_region <= R_DM;
      r_last   <= 1'b1;
      r_owner  <= 1'b0;
      r_first  <= 1'b0;
      r_we     <= 1'b0;
      r_cnt    <= 4'd0;
      r_be     <= 4'h0;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
    end else begin
      r_state <= w_next;
      r_first <= 1'b0;
      if (r_state == IDLE && w_any) begin
        r_owner  <= w_gnt1;
        r_region <= w_region;
        r_we     <= w_we;
        r_be     <= w_be;
        r_addr   <= w_addr;
        r_wdata  <= w_wdata;
        r_first  <= 1'b1;
        r_cnt    <= (w_region == R_DM) ? 4'(DM_LATENCY - 1) : 4'd0;
      end else if (r_state == ACCESS && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_ack) r_last <= r_owner;
    end
  end

  assign w_ack = (r_state == ACCESS) && (r_cnt == 4'd0);
  assign w_stb = (r_state == ACCESS) && r_first && r_we;
  assign w_rd  = (r_we || r_region == R_ERR) ? 32'h0 :
                 (r_region == R_DM)  ? dm_rdata  :
                 (r_region == R_TC1) ? tc1_rdata :
                 (r_region == R_TC2) ? tc2_rdata : int_rdata;

  assign m0_ack     = w_ack & ~r_owner;
  assign m1_ack     = w_ack & r_owner;
  assign m0_err     = m0_ack & (r_region == R_ERR);
  assign m1_err     = m1_ack & (r_region == R_ERR);
  assign m0_rdata   = m0_ack ? w_rd : 32'h0;
  assign m1_rdata   = m1_ack ? w_rd : 32'h0;
  assign dm_we      = w_stb && r_region == R_DM;
  assign tc1_we     = w_stb && r_region == R_TC1;
  assign tc2_we     = w_stb && r_region == R_TC2;
  assign int_we     = w_stb && r_region == R_INT;
  assign bus_addr   = r_addr;
  assign bus_byteen = r_be;
  assign bus_wdata  = r_wdata;
  assign busy       = r_state != IDLE;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed checks of arbitration, decode, latency and reset.
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_byteen, m1_byteen;
  logic [31:0] tc1_rdata, tc2_rdata, int_rdata, dm_rdata, dm_rdata1;

  logic        m0_ack, m0_err, m1_ack, m1_err, dm_we, tc1_we, tc2_we, int_we, busy;
  logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_byteen;

  logic        m0_ack1, m0_err1, m1_ack1, m1_err1, dm_we1, tc1_we1, tc2_we1, int_we1, busy1;
  logic [31:0] m0_rdata1, m1_rdata1, bus_addr1, bus_wdata1;
  logic [3:0]  bus_byteen1;

  assign dm_rdata  = bus_addr ^ 32'hCAFE_0000;
  assign dm_rdata1 = bus_addr1 ^ 32'hCAFE_0000;

  mem_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_byteen(m0_byteen), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_byteen(m1_byteen), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .bus_addr(bus_addr), .bus_byteen(bus_byteen), .bus_wdata(bus_wdata),
    .dm_we(dm_we), .tc1_we(tc1_we), .tc2_we(tc2_we), .int_we(int_we),
    .dm_rdata(dm_rdata), .tc1_rdata(tc1_rdata), .tc2_rdata(tc2_rdata), .int_rdata(int_rdata),
    .busy(busy)
  );

  mem_bus_arbiter #(.DM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_byteen(m0_byteen), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack1), .m0_err(m0_err1), .m0_rdata(m0_rdata1),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_byteen(m1_byteen), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack1), .m1_err(m1_err1), .m1_rdata(m1_rdata1),
    .bus_addr(bus_addr1), .bus_byteen(bus_byteen1), .bus_wdata(bus_wdata1),
    .dm_we(dm_we1), .tc1_we(tc1_we1), .tc2_we(tc2_we1), .int_we(int_we1),
    .dm_rdata(dm_rdata1), .tc1_rdata(tc1_rdata), .tc2_rdata(tc2_rdata), .int_rdata(int_rdata),
    .busy(busy1)
  );

  int pass_cnt = 0;
  int total = 0;

  // drives one request and observes it through RECOVER back to IDLE; cyc=0 means no ack
  task automatic run(input logic m, input logic we, input logic [31:0] a, input logic [3:0] be,
                     input logic [31:0] wd, output int cyc, output logic err, output logic [31:0] rd,
                     output logic [3:0] stb, output logic other, output logic rec_ok);
    cyc = 0; err = 0; rd = 0; stb = 0; other = 0; rec_ok = 0;
    if (m) begin
      m1_req = 1; m1_we = we; m1_addr = a; m1_byteen = be; m1_wdata = wd;
    end else begin
      m0_req = 1; m0_we = we; m0_addr = a; m0_byteen = be; m0_wdata = wd;
    end
    for (int n = 1; n <= 20 && cyc == 0; n++) begin
      @(negedge clk);
      stb |= {int_we, tc2_we, tc1_we, dm_we};
      if (m ? m0_ack : m1_ack) other = 1;
      if (m ? m1_ack : m0_ack) begin
        cyc = n; err = m ? m1_err : m0_err; rd = m ? m1_rdata : m0_rdata;
      end
    end
    m0_req = 0; m1_req = 0;
    @(negedge clk);
    rec_ok = busy && !m0_ack && !m1_ack && {int_we, tc2_we, tc1_we, dm_we} == 4'h0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    #2;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy_async: got %b want 0", busy); else pass_cnt++;
    @(negedge clk);
    total++; if ({m0_ack, m1_ack, m0_err, m1_err} !== 4'h0) $display("FAIL reset_acks: got %b want 0000", {m0_ack, m1_ack, m0_err, m1_err}); else pass_cnt++;
    total++; if ({dm_we, tc1_we, tc2_we, int_we} !== 4'h0) $display("FAIL reset_strobes: got %b want 0000", {dm_we, tc1_we, tc2_we, int_we}); else pass_cnt++;
    total++; if ({bus_addr, bus_wdata, bus_byteen} !== 68'h0) $display("FAIL reset_bus: got %h/%h/%h want 0", bus_addr, bus_wdata, bus_byteen); else pass_cnt++;
    total++; if ({m0_rdata, m1_rdata} !== 64'h0) $display("FAIL reset_rdata: got %h/%h want 0", m0_rdata, m1_rdata); else pass_cnt++;
    reset = 0;
  endtask

  task automatic test_dm_write;
    @(negedge clk);
    m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_byteen = 4'hF; m0_wdata = 32'hDEADBEEF;
    @(negedge clk);
    total++; if (dm_we !== 1'b1) $display("FAIL dmw_strobe: got %b want 1", dm_we); else pass_cnt++;
    total++; if (bus_addr !== 32'h10) $display("FAIL dmw_addr: got %h want 00000010", bus_addr); else pass_cnt++;
    total++; if (bus_wdata !== 32'hDEADBEEF) $display("FAIL dmw_wdata: got %h want deadbeef", bus_wdata); else pass_cnt++;
    total++; if (m0_ack !== 1'b0 || busy !== 1'b1) $display("FAIL dmw_early: ack %b busy %b want 0 1", m0_ack, busy); else pass_cnt++;
    @(negedge clk);
    total++; if (m0_ack !== 1'b1 || m0_err !== 1'b0) $display("FAIL dmw_ack: ack %b err %b want 1 0", m0_ack, m0_err); else pass_cnt++;
    total++; if (dm_we !== 1'b0 || m0_rdata !== 32'h0) $display("FAIL dmw_second: we %b rdata %h want 0 0", dm_we, m0_rdata); else pass_cnt++;
    m0_req = 0;
    @(negedge clk);
    total++; if (busy !== 1'b1 || m0_ack !== 1'b0) $display("FAIL dmw_recover: busy %b ack %b want 1 0", busy, m0_ack); else pass_cnt++;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL dmw_idle: busy %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_round_robin;
    logic e0, e1;
    @(negedge clk); reset = 1; #1 reset = 0;
    m0_req = 1; m0_we = 0; m0_addr = 32'h100; m0_byteen = 4'hF;
    m1_req = 1; m1_we = 0; m1_addr = 32'h200; m1_byteen = 4'hF;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      e0 = (n == 2 || n == 10);
      e1 = (n == 6 || n == 14);
      total++; if ({m0_ack, m1_ack} !== {e0, e1}) $display("FAIL rr_acks_cycle%0d: got %b%b want %b%b", n, m0_ack, m1_ack, e0, e1); else pass_cnt++;
      total++; if (m0_rdata !== (e0 ? 32'hCAFE_0100 : 32'h0)) $display("FAIL rr_m0_rdata_cycle%0d: got %h want %h", n, m0_rdata, e0 ? 32'hCAFE_0100 : 32'h0); else pass_cnt++;
      total++; if (m1_rdata !== (e1 ? 32'hCAFE_0200 : 32'h0)) $display("FAIL rr_m1_rdata_cycle%0d: got %h want %h", n, m1_rdata, e1 ? 32'hCAFE_0200 : 32'h0); else pass_cnt++;
    end
    m0_req = 0; m1_req = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tc_read;
    int cyc; logic err, other, rec; logic [31:0] rd; logic [3:0] stb;
    tc1_rdata = 32'h0000_1234;
    run(1'b1, 1'b0, 32'h7F04, 4'hF, 32'h0, cyc, err, rd, stb, other, rec);
    total++; if (cyc !== 1) $display("FAIL tc_latency: got %0d want 1", cyc); else pass_cnt++;
    total++; if (rd !== 32'h1234 || err !== 1'b0) $display("FAIL tc_rdata: got %h err %b want 00001234 0", rd, err); else pass_cnt++;
    total++; if (stb !== 4'h0 || other !== 1'b0) $display("FAIL tc_nostrobe: stb %b other %b want 0000 0", stb, other); else pass_cnt++;
    total++; if (rec !== 1'b1) $display("FAIL tc_recover: got %b want 1", rec); else pass_cnt++;
  endtask

  task automatic test_decode;
    logic [31:0] a   [7] = '{32'h7F08, 32'h7F10, 32'h3000, 32'h2FFC, 32'h7F14, 32'h7F20, 32'h20};
    logic [3:0]  be  [7] = '{4'hF, 4'b0011, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0};
    logic        we  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        xe  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    int          xc  [7] = '{1, 1, 1, 2, 1, 1, 1};
    logic [3:0]  xs  [7] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'b0100, 4'b1000, 4'h0};
    logic [31:0] xr  [7] = '{32'h0, 32'h0, 32'h0, 32'hCAFE_2FFC, 32'h0, 32'h0, 32'h0};
    int cyc; logic err, other, rec; logic [31:0] rd; logic [3:0] stb;
    for (int i = 0; i < 7; i++) begin
      run(1'b0, we[i], a[i], be[i], 32'h5555_AAAA, cyc, err, rd, stb, other, rec);
      total++; if (cyc !== xc[i] || err !== xe[i]) $display("FAIL decode%0d_ack: cyc %0d err %b want %0d %b", i, cyc, err, xc[i], xe[i]); else pass_cnt++;
      total++; if (stb !== xs[i] || rd !== xr[i]) $display("FAIL decode%0d_data: stb %b rdata %h want %b %h", i, stb, rd, xs[i], xr[i]); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid;
    int cyc; logic err, other, rec, seen; logic [31:0] rd; logic [3:0] stb;
    @(negedge clk);
    m0_req = 1; m0_we = 0; m0_addr = 32'h40; m0_byteen = 4'hF;
    @(negedge clk);
    total++; if (busy !== 1'b1) $display("FAIL rmid_busy: got %b want 1", busy); else pass_cnt++;
    @(posedge clk); #2 reset = 1; #1;
    total++; if (busy !== 1'b0 || m0_ack !== 1'b0) $display("FAIL rmid_clear: busy %b ack %b want 0 0", busy, m0_ack); else pass_cnt++;
    total++; if (bus_addr !== 32'h0 || m0_rdata !== 32'h0) $display("FAIL rmid_bus: addr %h rdata %h want 0 0", bus_addr, m0_rdata); else pass_cnt++;
    @(negedge clk); reset = 0; m0_req = 0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (m0_ack || m1_ack || busy) seen = 1;
    end
    total++; if (seen !== 1'b0) $display("FAIL rmid_quiet: got %b want 0", seen); else pass_cnt++;
    run(1'b0, 1'b0, 32'h80, 4'hF, 32'h0, cyc, err, rd, stb, other, rec);
    total++; if (cyc !== 2 || err !== 1'b0) $display("FAIL rmid_next: cyc %0d err %b want 2 0", cyc, err); else pass_cnt++;
    total++; if (rd !== 32'hCAFE_0080) $display("FAIL rmid_rdata: got %h want cafe0080", rd); else pass_cnt++;
  endtask

  task automatic test_lat1;
    logic [31:0] a [4] = '{32'h300, 32'h304, 32'h308, 32'h30C};
    int idx = 0;
    logic e;
    @(negedge clk); reset = 1; #1 reset = 0;
    m0_req = 1; m0_we = 0; m0_addr = a[0]; m0_byteen = 4'hF;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      e = (n % 3 == 1);
      total++; if (m0_ack1 !== e) $display("FAIL lat1_ack_cycle%0d: got %b want %b", n, m0_ack1, e); else pass_cnt++;
      if (e && idx < 4) begin
        total++; if (m0_rdata1 !== (a[idx] ^ 32'hCAFE_0000)) $display("FAIL lat1_rdata%0d: got %h want %h", idx, m0_rdata1, a[idx] ^ 32'hCAFE_0000); else pass_cnt++;
        idx++;
        if (idx < 4) m0_addr = a[idx];
      end
    end
    total++; if (idx !== 4) $display("FAIL lat1_count: got %0d want 4", idx); else pass_cnt++;
    m0_req = 0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset = 1;
    {m0_req, m0_we, m1_req, m1_we} = 4'h0;
    {m0_addr, m0_wdata, m1_addr, m1_wdata} = 128'h0;
    {m0_byteen, m1_byteen} = 8'h0;
    {tc1_rdata, tc2_rdata, int_rdata} = {32'h0, 32'h0, 32'h0};
    test_reset;
    test_dm_write;
    test_round_robin;
    test_tc_read;
    test_decode;
    test_reset_mid;
    test_lat1;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
